// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller for the 4-bit integer ALU.
// Takes one op at a time over a valid/ready request port, runs it, and holds
// the result on a valid/ready response port until it is consumed.
// AND/OR/XOR/XNOR/ADD/SUB finish one cycle after accept. MUL (shift-add) and
// SHL (one bit per step) iterate one step per cycle.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   request handshake; op, a, b sampled on accept
//   out_valid/out_ready response handshake; result held while out_valid=1
//   result [2*WIDTH-1:0]
//   busy                high while executing or holding a result
// Optional (`define ALU_FLAGS_EN): zero_flag, carry_flag, registered with result.
module alu_op_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
`ifdef ALU_FLAGS_EN
  ,
  output logic               zero_flag,
  output logic               carry_flag
`endif
);

  localparam int RW = 2*WIDTH;
  localparam logic [2:0] OP_AND = 3'b000, OP_OR  = 3'b001, OP_XOR = 3'b010,
                         OP_XNOR = 3'b011, OP_ADD = 3'b100, OP_SUB = 3'b101,
                         OP_MUL = 3'b110, OP_SHL = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_r;
  logic [RW-1:0]    acc;     // result register; also the running accumulator / shifter
  logic [RW-1:0]    mcand;   // MUL multiplicand, shifted left each step
  logic [WIDTH-1:0] mplier;  // MUL multiplier, shifted right each step
  logic [WIDTH-1:0] cnt;     // remaining steps; WIDTH bits cover both WIDTH and b_max
  logic             accept;
  logic             last_step;
  logic [RW-1:0]    quick_res;
  logic [RW-1:0]    step_acc;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == EXEC) || (state == DONE);
  assign result    = acc;
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == WIDTH'(1));

  // Value loaded into acc on accept. For MUL this is the cleared accumulator,
  // for SHL the unshifted operand (which is already final when b==0).
  always_comb begin
    quick_res = '0;
    case (op)
      OP_AND:  quick_res[WIDTH-1:0] = a & b;
      OP_OR:   quick_res[WIDTH-1:0] = a | b;
      OP_XOR:  quick_res[WIDTH-1:0] = a ^ b;
      OP_XNOR: quick_res[WIDTH-1:0] = ~(a ^ b);
      OP_ADD:  quick_res[WIDTH:0]   = {1'b0, a} + {1'b0, b};
      OP_SUB:  quick_res[WIDTH:0]   = {1'b0, a} - {1'b0, b};
      OP_MUL:  quick_res = '0;
      OP_SHL:  quick_res[WIDTH-1:0] = a;
      default: quick_res = '0;
    endcase
  end

  // One iteration of the op in flight.
  always_comb begin
    step_acc = acc << 1;
    if (op_r == OP_MUL)
      step_acc = acc + (mplier[0] ? mcand : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (op == OP_MUL || (op == OP_SHL && b != '0)) state_nxt = EXEC;
        else                                          state_nxt = DONE;
      end
      EXEC: if (last_step) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ALU_FLAGS_EN
  function automatic logic carry_of(input logic [2:0] o, input logic [RW-1:0] r);
    if (o == OP_ADD || o == OP_SUB) return r[WIDTH];
    if (o == OP_MUL || o == OP_SHL) return |r[RW-1:WIDTH];
    return 1'b0;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`ifdef ALU_FLAGS_EN
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_r   <= op;
          acc    <= quick_res;
          mcand  <= {{WIDTH{1'b0}}, a};
          mplier <= b;
          cnt    <= (op == OP_MUL) ? WIDTH'(WIDTH) : b;
`ifdef ALU_FLAGS_EN
          zero_flag  <= (quick_res == '0);
          carry_flag <= carry_of(op, quick_res);
`endif
        end
        EXEC: begin
          acc    <= step_acc;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - WIDTH'(1);
`ifdef ALU_FLAGS_EN
          if (last_step) begin
            zero_flag  <= (step_acc == '0);
            carry_flag <= carry_of(op_r, step_acc);
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [2:0]     op = '0;
  logic [W-1:0]   a = '0, b = '0;
  logic           in_ready, out_valid, busy;
  logic [2*W-1:0] result;
`ifdef ALU_FLAGS_EN
  logic           zero_flag, carry_flag;
`endif

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
`ifdef ALU_FLAGS_EN
    , .zero_flag(zero_flag), .carry_flag(carry_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
    int         lat;
    int         hold;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: results straight from the arithmetic definitions.
  function automatic logic [7:0] model(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
    int xv = int'(x);
    int yv = int'(y);
    case (o)
      3'd0: return {4'h0, x & y};
      3'd1: return {4'h0, x | y};
      3'd2: return {4'h0, x ^ y};
      3'd3: return {4'h0, ~(x ^ y)};
      3'd4: return 8'(xv + yv);
      3'd5: return 8'((xv - yv) & 31);
      3'd6: return 8'(xv * yv);
      default: return 8'((xv << yv) & 255);
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [3:0] y);
    if (o == 3'd6) return 1 + W;
    if (o == 3'd7) return 1 + int'(y);
    return 1;
  endfunction

  function automatic logic model_carry(input logic [2:0] o, input logic [7:0] r);
    if (o == 3'd4 || o == 3'd5) return r[4];
    if (o == 3'd6 || o == 3'd7) return |r[7:4];
    return 1'b0;
  endfunction

  // Issue one op from IDLE (called just after a rising edge), wait for the
  // result with a bounded loop, hold it under backpressure, then consume it.
  task automatic run_op(input string name, input logic [2:0] o, input logic [3:0] x,
                        input logic [3:0] y, input logic [7:0] exp, input int lat, input int hold);
    int k;
    check({name, ".in_ready"}, in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    k = 1;
    while (!out_valid && k < 64) begin
      check({name, ".busy"}, busy, 1);
      check({name, ".in_ready_exec"}, in_ready, 0);
      // Garbage on the request port must not disturb the op in flight.
      in_valid = 1'($urandom); op = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    check({name, ".latency"}, k, lat);
    check({name, ".out_valid"}, out_valid, 1);
    check({name, ".result"}, result, exp);
    check({name, ".busy_done"}, busy, 1);
`ifdef ALU_FLAGS_EN
    check({name, ".zero_flag"}, zero_flag, exp == 8'h00);
    check({name, ".carry_flag"}, carry_flag, model_carry(o, exp));
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      check({name, ".hold_result"}, result, exp);
      check({name, ".hold_valid"}, out_valid, 1);
      check({name, ".hold_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, ".release_valid"}, out_valid, 0);
    check({name, ".release_in_ready"}, in_ready, 1);
    check({name, ".release_busy"}, busy, 0);
  endtask

  initial begin
    logic [2:0] ro;
    logic [3:0] ra, rb;

    vecs[0] = '{3'b011, 4'hC, 4'h9, 8'h0A, 1,  0};
    vecs[1] = '{3'b100, 4'h9, 4'h8, 8'h11, 1,  0};
    vecs[2] = '{3'b101, 4'h3, 4'h5, 8'h1E, 1,  0};
    vecs[3] = '{3'b110, 4'hF, 4'hF, 8'hE1, 5,  1};
    vecs[4] = '{3'b111, 4'h3, 4'h3, 8'h18, 4,  0};
    vecs[5] = '{3'b111, 4'h3, 4'h0, 8'h03, 1,  0};
    vecs[6] = '{3'b111, 4'hF, 4'h9, 8'h00, 10, 0};
    vecs[7] = '{3'b010, 4'hA, 4'h6, 8'h0C, 1,  3};
    vecs[8] = '{3'b001, 4'hA, 4'h5, 8'h0F, 1,  0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset.in_ready", in_ready, 1);
    check("reset.out_valid", out_valid, 0);
    check("reset.result", result, 0);
    check("reset.busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset.in_ready", in_ready, 1);

    // Directed vectors
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat, vecs[i].hold);

    // Reset mid-MUL: aborts immediately, nothing presented
    op = 3'b110; a = 4'd7; b = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midreset.out_valid", out_valid, 0);
    check("midreset.result", result, 0);
    check("midreset.in_ready", in_ready, 1);
    check("midreset.busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_reset.idle", in_ready, 1);
    run_op("after_reset.and", 3'b000, 4'hF, 4'h5, 8'h05, 1, 0);

    // Random ops against the reference model
    for (int n = 0; n < 60; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 4'($urandom);
      rb = 4'($urandom);
      run_op($sformatf("rand%0d", n), ro, ra, rb, model(ro, ra, rb),
             model_lat(ro, rb), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
